// File: rtl/mole_scheduler_pkg.sv
// mole_scheduler_pkg: state encodings, difficulty codes and default ms constants for the mole scheduler
package mole_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_UP, ST_FLASH} state_t;
  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;
  localparam logic [1:0] DIFF_XHARD = 2'd3;
  localparam int DEF_GAP_MS = 300;
  localparam int DEF_FLASH_MS = 150;
  localparam int DEF_UP_MS_EASY = 1000;
  localparam int DEF_UP_MS_MED = 700;
  localparam int DEF_UP_MS_HARD = 450;
  localparam int CNT_W = 11;
  // difficulty 3 shares the hard up-time
  function automatic logic [CNT_W-1:0] up_time(input logic [1:0] d, input int e, input int m, input int h);
    return d == DIFF_EASY ? CNT_W'(e) : d == DIFF_MED ? CNT_W'(m) : CNT_W'(h);
  endfunction
endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), exposes its low W bits
module mole_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] rnd
);
  logic [15:0] lfsr_q, lfsr_d;
  // shift left, feedback enters at bit 0; steps every cycle regardless of game state
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // seed only on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign rnd = lfsr_q[W-1:0];
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: spawns pseudo-random moles, times them and judges button hits; MOLE_MISS_PULSE_EN enables miss_pulse
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int NUM_HOLES = 8,
  parameter int GAP_MS = DEF_GAP_MS,
  parameter int FLASH_MS = DEF_FLASH_MS,
  parameter int UP_MS_EASY = DEF_UP_MS_EASY,
  parameter int UP_MS_MED = DEF_UP_MS_MED,
  parameter int UP_MS_HARD = DEF_UP_MS_HARD,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int IDX = $clog2(NUM_HOLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           difficulty,
  input  logic                 tick_ms,
  input  logic [NUM_HOLES-1:0] btn_hit,
  output logic [NUM_HOLES-1:0] mole_leds,
  output logic                 mole_active,
  output logic [IDX-1:0]       mole_index,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_MS - 1);
  localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(FLASH_MS - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, up_ms_q, up_ms_d;
  logic [IDX-1:0] idx_q, idx_d, cand;
  logic [NUM_HOLES-1:0] leds_q, leds_d;
  logic hit_q, hit_d, timeout;
  mole_lfsr #(.SEED(LFSR_SEED), .W(IDX)) u_lfsr (.clk(clk), .rst_n(rst_n), .rnd(cand));
  assign timeout = tick_ms && cnt_q == up_ms_q - CNT_W'(1);
  // next state, mole pick, counter and display; disable overrides everything
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    up_ms_d = up_ms_q;
    hit_d = 1'b0;
    if (!enable) state_d = ST_IDLE;
    else
      case (state_q)
        ST_IDLE: state_d = ST_GAP;
        ST_GAP:
          if (tick_ms && cnt_q == GAP_END) begin
            state_d = ST_UP;
            idx_d = cand == idx_q ? cand + IDX'(1) : cand;
            up_ms_d = up_time(difficulty, UP_MS_EASY, UP_MS_MED, UP_MS_HARD);
          end
        ST_UP:
          if (btn_hit[idx_q]) begin
            state_d = ST_FLASH;
            hit_d = 1'b1;
          end else if (timeout) state_d = ST_GAP;
        default: if (tick_ms && cnt_q == FLASH_END) state_d = ST_GAP;
      endcase
    cnt_d = (state_d != state_q || state_d == ST_IDLE) ? '0 : cnt_q + CNT_W'(tick_ms);
    leds_d = state_d == ST_UP ? NUM_HOLES'(1) << idx_d : '0;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      up_ms_q <= '0;
      leds_q <= '0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      up_ms_q <= up_ms_d;
      leds_q <= leds_d;
      hit_q <= hit_d;
    end
`ifdef MOLE_MISS_PULSE_EN
  logic miss_q, miss_d;
  // a timeout only counts as a miss when no hit and no disable coincide with it
  always_comb miss_d = enable && state_q == ST_UP && !btn_hit[idx_q] && timeout;
  // one-cycle miss pulse register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) miss_q <= 1'b0;
    else miss_q <= miss_d;
  assign miss_pulse = miss_q;
`else
  assign miss_pulse = 1'b0;
`endif
  assign mole_leds = leds_q;
  assign mole_active = state_q == ST_UP;
  assign mole_index = idx_q;
  assign hit_pulse = hit_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed scoreboard bench for mole_scheduler with scaled 3/2/10/7/4 tick timing
module tb_mole_scheduler;
  logic clk = 0, rst_n = 0, enable = 0, tick_ms = 0;
  logic [1:0] difficulty = 0;
  logic [7:0] btn_hit = 0;
  logic [7:0] mole_leds;
  logic mole_active, hit_pulse, miss_pulse;
  logic [2:0] mole_index;
  int n_chk = 0, n_fail = 0;
  typedef struct {bit hit; logic [2:0] idx;} exp_t;
  exp_t sb[$];
`ifdef MOLE_MISS_PULSE_EN
  localparam bit MISS_ON = 1'b1;
`else
  localparam bit MISS_ON = 1'b0;
`endif
  mole_scheduler #(.NUM_HOLES(8), .GAP_MS(3), .FLASH_MS(2), .UP_MS_EASY(10), .UP_MS_MED(7), .UP_MS_HARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .difficulty(difficulty), .tick_ms(tick_ms), .btn_hit(btn_hit),
    .mole_leds(mole_leds), .mole_active(mole_active), .mole_index(mole_index), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic t, input logic [7:0] b);
    tick_ms = t;
    btn_hit = b;
    @(posedge clk);
    #1;
    tick_ms = 0;
    btn_hit = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) step(1'b1, 8'h00);
  endtask
  task automatic push(input bit h, input logic [2:0] i);
    exp_t e;
    e.hit = h;
    e.idx = i;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (hit_pulse || miss_pulse)) begin
      n_chk++;
      if (hit_pulse && miss_pulse) begin
        n_fail++;
        $display("FAIL pulse_both: hit=%0b miss=%0b expected only one", hit_pulse, miss_pulse);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: hit=%0b miss=%0b expected none", hit_pulse, miss_pulse);
      end else begin
        e = sb.pop_front();
        if (e.hit !== hit_pulse || e.idx !== mole_index) begin
          n_fail++;
          $display("FAIL pulse_kind: hit=%0b idx=%0d expected hit=%0b idx=%0d", hit_pulse, mole_index, e.hit, e.idx);
        end
      end
    end
  end
  initial begin
    logic [2:0] idx, prev;
    logic [7:0] m;
    bit seen [8];
    #23;
    chk("rst_leds", mole_leds, 0);
    chk("rst_active", mole_active, 0);
    chk("rst_index", mole_index, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0);
    enable = 1;
    step(0, 0);
    chk("gap_leds0", mole_leds, 0);
    ticks(2);
    chk("gap_leds2", mole_leds, 0);
    chk("gap_active2", mole_active, 0);
    ticks(1);
    chk("up_active", mole_active, 1);
    chk("up_onehot", $countones(mole_leds), 1);
    chk("up_led_idx", mole_leds, 8'h01 << mole_index);
    idx = mole_index;
    m = 8'h01 << idx;
    push(1, idx);
    step(0, m);
    chk("hit_pulse", hit_pulse, 1);
    chk("hit_leds", mole_leds, 0);
    step(0, m);
    chk("flash_press", hit_pulse, 0);
    ticks(2);
    difficulty = 2;
    ticks(3);
    chk("t3_active", mole_active, 1);
    idx = mole_index;
    m = 8'h01 << idx;
    ticks(3);
    chk("t3_led_on3", mole_leds, m);
    if (MISS_ON) push(0, idx);
    ticks(1);
    chk("t3_led_off", mole_leds, 0);
    chk("t3_miss", miss_pulse, MISS_ON);
    step(0, 0);
    chk("t3_miss_1cyc", miss_pulse, 0);
    difficulty = 1;
    ticks(2);
    chk("t4_gap", mole_active, 0);
    ticks(1);
    idx = mole_index;
    m = 8'h01 << idx;
    step(0, ~m);
    chk("wrong_active", mole_active, 1);
    chk("wrong_leds", mole_leds, m);
    chk("wrong_hit", hit_pulse, 0);
    difficulty = 2;
    ticks(6);
    chk("diff_latched", mole_active, 1);
    push(1, idx);
    step(1, m);
    chk("tie_hit", hit_pulse, 1);
    chk("tie_miss", miss_pulse, 0);
    chk("tie_leds", mole_leds, 0);
    step(0, 0);
    chk("tie_miss_after", miss_pulse, 0);
    ticks(5);
    prev = mole_index;
    seen[prev] = 1;
    for (int i = 0; i < 200; i++) begin
      idx = mole_index;
      chk("nr_active", mole_active, 1);
      if (i > 0) chk("no_repeat", idx != prev, 1);
      seen[idx] = 1;
      prev = idx;
      push(1, idx);
      step(0, 8'h01 << idx);
      ticks(5);
    end
    for (int i = 0; i < 8; i++) chk("all_seen", seen[i], 1);
    idx = mole_index;
    ticks(1);
    enable = 0;
    step(0, 8'h01 << idx);
    chk("dis_leds", mole_leds, 0);
    chk("dis_active", mole_active, 0);
    chk("dis_hit", hit_pulse, 0);
    ticks(3);
    chk("idle_leds", mole_leds, 0);
    enable = 1;
    step(0, 0);
    ticks(2);
    chk("reen_gap2", mole_active, 0);
    ticks(1);
    chk("reen_up", mole_active, 1);
    step(0, 0);
    step(0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
